// File: rtl/icache_pkg.sv
// ============================================================================
//  Module  : icache_pkg
//  Brief   : Shared constants for the direct-mapped instruction cache.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

  localparam int OFF_W = 2;

  localparam logic [1:0] ICACHE_IDLE    = 2'd0;
  localparam logic [1:0] ICACHE_REFILL  = 2'd1;
  localparam logic [1:0] ICACHE_RESPOND = 2'd2;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef logic [1:0] icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_data_array.sv
// ============================================================================
//  Module  : icache_data_array
//  Brief   : Line storage, combinational read port and synchronous write port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache_data_array
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [$clog2(LINES)-1:0]          line,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] word,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [$clog2(LINES)-1:0]          rline,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] rword,
  output logic [DATA_WIDTH-1:0]             rdata
);

  logic [DATA_WIDTH-1:0] r_mem [LINES*WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[{line, word}] <= wdata;
    end
  end

  assign rdata = r_mem[{rline, rword}];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  Module  : icache
//  Brief   : Direct-mapped read-only instruction cache with whole-line refill.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = DATA_WIDTH - IDX_W - WORD_W - OFF_W;

  localparam logic [WORD_W-1:0] c_last_word = WORD_W'(WORDS_PER_LINE - 1);

  icache_state_t         r_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag_mem [LINES];
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_W-1:0]     r_word;
  logic [WORD_W-1:0]     r_cnt;
  logic                  r_flush_seen;
  logic                  r_mem_req;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic                  r_inst_valid;
  logic [DATA_WIDTH-1:0] r_inst_data;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [WORD_W-1:0]     w_word;
  logic                  w_hit;
  logic                  w_last;
  logic                  w_fill_we;
  logic [IDX_W-1:0]      w_rd_line;
  logic [WORD_W-1:0]     w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_addr;

  assign w_tag         = inst_addr[DATA_WIDTH-1 -: TAG_W];
  assign w_idx         = inst_addr[OFF_W+WORD_W +: IDX_W];
  assign w_word        = inst_addr[OFF_W +: WORD_W];
  assign w_unused_addr = ^inst_addr[OFF_W-1:0];

  // A flush coinciding with a lookup forces the miss path.
  assign w_hit     = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag) && !flush;
  assign w_last    = (r_cnt == c_last_word);
  assign w_fill_we = (r_state == ICACHE_REFILL) && mem_valid;

  // The single read port looks up the fetch in IDLE and the pending word during refill.
  assign w_rd_line = (r_state == ICACHE_IDLE) ? w_idx  : r_idx;
  assign w_rd_word = (r_state == ICACHE_IDLE) ? w_word : r_word;

  icache_data_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_array (
    .clk   (clk),
    .we    (w_fill_we),
    .line  (r_idx),
    .word  (r_cnt),
    .wdata (mem_rdata),
    .rline (w_rd_line),
    .rword (w_rd_word),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (w_fill_we && w_last) begin
      r_tag_mem[r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ICACHE_IDLE;
      r_valid      <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_cnt        <= '0;
      r_flush_seen <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
    end else begin
      r_inst_valid <= 1'b0;
      if (flush) begin
        r_valid <= '0;
      end
      case (r_state)
        ICACHE_IDLE: begin
          if (inst_req) begin
            if (w_hit) begin
              r_inst_data  <= w_rd_data;
              r_inst_valid <= 1'b1;
              r_state      <= ICACHE_RESPOND;
            end else begin
              r_tag        <= w_tag;
              r_idx        <= w_idx;
              r_word       <= w_word;
              r_cnt        <= '0;
              r_flush_seen <= 1'b0;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= {w_tag, w_idx, {WORD_W{1'b0}}, {OFF_W{1'b0}}};
              r_state      <= ICACHE_REFILL;
            end
          end
        end
        ICACHE_REFILL: begin
          if (flush) begin
            r_flush_seen <= 1'b1;
          end
          if (mem_valid) begin
            if (!w_last) begin
              r_cnt      <= r_cnt + 1'b1;
              r_mem_addr <= r_mem_addr + DATA_WIDTH'(4);
            end else begin
              r_mem_req <= 1'b0;
              // A flush seen at any point of the refill leaves the line invalid.
              if (!(r_flush_seen || flush)) begin
                r_valid[r_idx] <= 1'b1;
              end
              r_inst_data  <= (r_word == c_last_word) ? mem_rdata : w_rd_data;
              r_inst_valid <= 1'b1;
              r_state      <= ICACHE_RESPOND;
            end
          end
        end
        ICACHE_RESPOND: begin
          r_state <= ICACHE_IDLE;
        end
        default: begin
          r_state <= ICACHE_IDLE;
        end
      endcase
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst_data  = r_inst_data;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module  : tb_icache
//  Brief   : Directed self-checking bench for icache against a line-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache;

  localparam int LINES = 16;
  localparam int WPL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  icache #(.DATA_WIDTH(32), .LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_serve_cyc = -1;
  logic [31:0] q_served [$];
  bit          busy = 1'b1;
  bit          slow = 1'b0;
  bit          resp_en = 1'b1;
  bit          m_valid [LINES];
  int unsigned m_tag [LINES];
  logic [31:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  // Backing memory: serves the held request after 0 (or 0..5 random) cycles.
  initial begin : g_responder
    bit          active;
    int          remaining;
    logic [31:0] held;
    active = 0;
    remaining = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        mem_valid = 1'b0;
        if (rst && mem_req) begin
          if (!active) begin
            active = 1;
            held = mem_addr;
            remaining = slow ? int'($urandom_range(0, 5)) : 0;
          end else begin
            check("mem_addr_hold", mem_addr, held);
          end
          if (remaining == 0) begin
            mem_valid = 1'b1;
            mem_rdata = mem_word(held);
            active = 0;
          end else begin
            remaining--;
          end
        end else begin
          active = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst && mem_req && mem_valid) begin
      q_served.push_back(mem_addr);
      last_serve_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst && !busy) begin
      check("idle_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("idle_mem_req", {31'b0, mem_req}, 32'd0);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  // flush_at: -1 none, 0 together with the request, k>0 at the k-th cycle after acceptance.
  task automatic fetch(input logic [31:0] a, input int flush_at);
    int          idx;
    int unsigned tag;
    bit          exp_hit;
    bit          exp_v;
    bit          got;
    bit          flushed;
    int          k;
    logic [31:0] base;
    idx  = int'((a / 16) % LINES);
    tag  = a / 256;
    base = a & ~32'hF;
    if (flush_at == 0) model_clear();
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    busy = 1'b1;
    q_served.delete();
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = a;
    flush     = (flush_at == 0);
    flushed   = (flush_at == 0);
    got = 0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      flush = 1'b0;
      exp_v = exp_hit ? (k == 1) : (q_served.size() == WPL && last_serve_cyc == cyc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_v});
      if (exp_hit) check("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
      else if (q_served.size() < WPL) check("mem_req_held", {31'b0, mem_req}, 32'd1);
      if (inst_valid) begin
        got = 1;
        inst_req = 1'b0;
        last_data = inst_data;
        check("inst_data", inst_data, mem_word(a & ~32'h3));
      end else if (k == flush_at) begin
        flush = 1'b1;
        flushed = 1;
      end
    end
    flush = 1'b0;
    inst_req = 1'b0;
    if (!got) timeout("fetch");
    if (exp_hit) begin
      check("hit_words", q_served.size(), 32'd0);
    end else begin
      check("miss_words", q_served.size(), WPL);
      for (int i = 0; i < WPL && i < q_served.size(); i++)
        check("refill_addr", q_served[i], base + 32'(4 * i));
      m_tag[idx] = tag;
      m_valid[idx] = 1;
    end
    if (flushed && flush_at > 0) model_clear();
    @(posedge clk);
    busy = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin : g_main
    int n;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    busy = 1'b0;
    repeat (2) @(negedge clk);

    // Cold miss, then hit in the refilled line.
    fetch(32'h100, -1);
    check("t1_data", last_data, 32'h11);
    check("t1_addr0", q_served.size() > 0 ? q_served[0] : 32'hX, 32'h100);
    check("t1_addr3", q_served.size() > 3 ? q_served[3] : 32'hX, 32'h10C);
    fetch(32'h108, -1);
    check("t2_data", last_data, 32'h33);
    fetch(32'h10C, -1);

    // Flush pulse forces a full refill.
    flush_pulse();
    fetch(32'h108, -1);
    check("t5_data", last_data, 32'h33);

    // Same index, different tag evicts.
    fetch(32'h100 + LINES * 16, -1);
    fetch(32'h100, -1);
    fetch(32'h104, -1);
    check("t3_data", last_data, 32'h22);

    // Slow memory.
    slow = 1'b1;
    fetch(32'h344, -1);
    fetch(32'h1FC, -1);
    fetch(32'hABC0_0008, -1);
    fetch(32'h348, -1);
    slow = 1'b0;

    // Flush inside a refill and flush together with a request.
    fetch(32'h500, 2);
    fetch(32'h500, -1);
    fetch(32'h504, -1);
    fetch(32'h540, 0);
    fetch(32'h544, -1);

    // Reset in the middle of a refill.
    busy = 1'b1;
    q_served.delete();
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = 32'h600;
    n = 0;
    while (q_served.size() < 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) timeout("reset_refill");
    rst = 1'b0;
    #1;
    check("arst_mem_req", {31'b0, mem_req}, 32'd0);
    check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    inst_req = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    resp_en = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_valid = 1'b0;
    check("late_mem_req", {31'b0, mem_req}, 32'd0);
    check("late_inst_valid", {31'b0, inst_valid}, 32'd0);
    resp_en = 1'b1;
    busy = 1'b0;
    fetch(32'h100, -1);
    check("t6_addr0", q_served.size() > 0 ? q_served[0] : 32'hX, 32'h100);
    check("t6_data", last_data, 32'h11);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
